// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared constants and helpers
// for the integer clock divider.
package clk_gen_pkg;

  localparam int DIV_MIN  = 2;
  localparam int DIV_MAX  = 65536;
  localparam int LOCK_MAX = 65535;
  localparam int LW       = 16;

  // Cycles of clkout high per period; odd ratios spend the extra cycle low.
  function automatic int high_of(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/clk_gen_lock.sv
// clk_gen_lock: saturating period counter
// with a sticky lock flag.
module clk_gen_lock
  import clk_gen_pkg::*;
#(
  parameter int LOCK_PERIODS = 16
) (
  input  logic clkin,
  input  logic reset,
  input  logic wrap,
  output logic lock
);

  localparam logic [LW-1:0] LP = LW'(LOCK_PERIODS);

  logic [LW-1:0] lcnt;
  logic [LW-1:0] lnext;

  assign lnext = lcnt + 16'd1;

  // Lock asserts on the very edge that completes the final period.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lcnt <= '0;
      lock <= 1'b0;
    end else if (wrap && !lock && (lcnt != '1)) begin
      lcnt <= lnext;
      if (lnext == LP) begin
        lock <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_gen_core.sv
// clk_gen_core: divides clkin by DIV into
// clkout, with tick strobe and lock flag.
module clk_gen_core
  import clk_gen_pkg::*;
#(
  parameter int DIV          = 2,
  parameter int LOCK_PERIODS = 16
) (
  input  logic clkin,
  input  logic reset,
  output logic clkout,
  output logic lock,
  output logic tick
);

  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int HIGH = high_of(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if ((DIV < DIV_MIN) || (DIV > DIV_MAX)) begin : g_bad_div
    $error("clk_gen_core: DIV %0d out of range", DIV);
  end

  if ((LOCK_PERIODS < 1) || (LOCK_PERIODS > LOCK_MAX)) begin : g_bad_lock
    $error("clk_gen_core: LOCK_PERIODS %0d out of range", LOCK_PERIODS);
  end

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt    <= '0;
      clkout <= 1'b0;
      tick   <= 1'b0;
    end else begin
      clkout <= (32'(cnt) < HIGH);
      tick   <= (cnt == '0);
      cnt    <= wrap ? '0 : cnt + 1'b1;
    end
  end

  clk_gen_lock #(
    .LOCK_PERIODS(LOCK_PERIODS)
  ) u_lock (
    .clkin(clkin),
    .reset(reset),
    .wrap (wrap),
    .lock (lock)
  );

endmodule

// File: tb/tb_clk_gen_core.sv
// tb_clk_gen_core: directed scoreboard bench
// over several divide ratios.
module tb_clk_gen_core;

  logic       clkin = 1'b0;
  logic [4:0] rst   = '1;
  logic [4:0] co, tk, lk;

  always #5 clkin = ~clkin;

  clk_gen_core #(.DIV(2), .LOCK_PERIODS(16)) u0 (
    .clkin(clkin), .reset(rst[0]),
    .clkout(co[0]), .lock(lk[0]), .tick(tk[0]));
  clk_gen_core #(.DIV(5), .LOCK_PERIODS(16)) u1 (
    .clkin(clkin), .reset(rst[1]),
    .clkout(co[1]), .lock(lk[1]), .tick(tk[1]));
  clk_gen_core #(.DIV(4), .LOCK_PERIODS(16)) u2 (
    .clkin(clkin), .reset(rst[2]),
    .clkout(co[2]), .lock(lk[2]), .tick(tk[2]));
  clk_gen_core #(.DIV(3), .LOCK_PERIODS(1)) u3 (
    .clkin(clkin), .reset(rst[3]),
    .clkout(co[3]), .lock(lk[3]), .tick(tk[3]));
  clk_gen_core #(.DIV(65536), .LOCK_PERIODS(1)) u4 (
    .clkin(clkin), .reset(rst[4]),
    .clkout(co[4]), .lock(lk[4]), .tick(tk[4]));

  typedef struct {
    int         inst;
    int         k;
    string      tag;
    logic [2:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  divs [5] = '{2, 5, 4, 3, 65536};
  int  lps  [5] = '{16, 16, 16, 1, 1};
  int  kk   [5] = '{0, 0, 0, 0, 0};
  int  n_chk  = 0;
  int  n_fail = 0;

  // Expected {clkout, tick, lock} after the k-th edge since release.
  function automatic logic [2:0] expect_of(int k, int div, int lp);
    int ph;
    if (k == 0) return 3'b000;
    ph = (k - 1) % div;
    return {ph < (div / 2), ph == 0, k >= lp * div};
  endfunction

  task automatic cyc(input int i, input bit rs, input bit chk,
                     input string tag);
    sb_t e;
    logic [2:0] obs;
    rst[i] = rs;
    kk[i]  = rs ? 0 : kk[i] + 1;
    if (chk) begin
      e.inst = i;
      e.k    = kk[i];
      e.tag  = tag;
      e.exp  = expect_of(kk[i], divs[i], lps[i]);
      sbq.push_back(e);
    end
    @(posedge clkin);
    #1;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = {co[e.inst], tk[e.inst], lk[e.inst]};
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s k=%0d {clkout,tick,lock} got %b exp %b",
               e.tag, e.k, obs, e.exp);
      end
    end
    @(negedge clkin);
  endtask

  initial begin
    @(negedge clkin);
    @(negedge clkin);

    for (int n = 0; n < 4; n++) cyc(0, 1'b1, 1'b1, "div2_reset");
    for (int n = 0; n < 40; n++) cyc(0, 1'b0, 1'b1, "div2_run");

    cyc(1, 1'b1, 1'b1, "div5_reset");
    for (int n = 0; n < 30; n++) cyc(1, 1'b0, 1'b1, "div5_run");

    for (int n = 0; n < 2; n++) cyc(2, 1'b1, 1'b1, "div4_reset");
    for (int n = 0; n < 70; n++) cyc(2, 1'b0, 1'b1, "div4_lock");
    cyc(2, 1'b1, 1'b1, "div4_midrst");
    for (int n = 0; n < 70; n++) cyc(2, 1'b0, 1'b1, "div4_relock");

    cyc(3, 1'b1, 1'b1, "lp1_reset");
    for (int n = 0; n < 1005; n++) cyc(3, 1'b0, 1'b1, "lp1_run");

    cyc(4, 1'b1, 1'b1, "div64k_reset");
    for (int n = 1; n <= 65538; n++) begin
      cyc(4, 1'b0,
          (n <= 2) || (n == 32768) || (n == 32769) ||
          (n == 65535) || (n == 65536) || (n == 65537),
          "div64k_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
